bus_timer: RTL and testbench

//   Memory-mapped down-counting timer; responder on one bus-matrix slave port (s3).
//   The CPU data bus, or uart_debug when debug_en is set, is the initiator.

---
 rtl/bus_timer_if.sv | 20 ++
 rtl/bus_timer.sv | 163 ++++++++++++++++
 tb/tb_bus_timer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_timer_if.sv
// Bus-matrix slave port bundle for the memory-mapped timer: address, strobes,
// write data, read data and the level interrupt back to the CPU.
interface bus_timer_if;
    logic [31:0] addr_i;
    logic        rd_i;
    logic        we_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        irq_o;

    modport master (
        output addr_i, rd_i, we_i, data_i,
        input  data_o, irq_o
    );

    modport slave (
        input  addr_i, rd_i, we_i, data_i,
        output data_o, irq_o
    );
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped down-counting timer with prescaler, one-shot/auto-reload modes
// and a level interrupt. Reads return the pre-update register value one cycle later.
module bus_timer #(
    parameter int unsigned    CNT_W      = 32,
    parameter int unsigned    PRESCALE_W = 16,
    parameter logic [CNT_W-1:0] LOAD_RST = {CNT_W{1'b0}}
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    bus_timer_if.slave bus
);

    localparam logic [5:0] OFF_CTRL     = 6'h00;
    localparam logic [5:0] OFF_LOAD     = 6'h01;
    localparam logic [5:0] OFF_COUNT    = 6'h02;
    localparam logic [5:0] OFF_STATUS   = 6'h03;
    localparam logic [5:0] OFF_PRESCALE = 6'h04;

    logic                  en_r, auto_r, irq_en_r, expired_r, irq_r;
    logic [CNT_W-1:0]      load_r, count_r;
    logic [PRESCALE_W-1:0] prescale_r, pcnt_r;
    logic [31:0]           rdata_r;

    logic                  en_nxt_s, auto_nxt_s, irq_en_nxt_s, expired_nxt_s, irq_nxt_s;
    logic [CNT_W-1:0]      load_nxt_s, count_nxt_s;
    logic [PRESCALE_W-1:0] prescale_nxt_s, pcnt_nxt_s;
    logic [31:0]           rd_val_s;
    logic                  wr_s, tick_s, expire_s;
    logic                  ctrl_wr_s, load_wr_s, count_wr_s, status_wr_s, prescale_wr_s;
    logic [5:0]            off_s;
    logic                  unused_s;

    // A simultaneous read strobe suppresses the write.
    assign off_s    = bus.addr_i[7:2];
    assign wr_s     = bus.we_i & ~bus.rd_i;
    assign tick_s   = en_r & (pcnt_r == prescale_r);
    assign expire_s = tick_s & (count_r == {CNT_W{1'b0}});
    assign unused_s = ^{bus.addr_i[31:8], bus.addr_i[1:0], bus.data_i};

    // Write-strobe decode per register offset
    always_comb begin
        ctrl_wr_s     = 1'b0;
        load_wr_s     = 1'b0;
        count_wr_s    = 1'b0;
        status_wr_s   = 1'b0;
        prescale_wr_s = 1'b0;
        case (off_s)
            OFF_CTRL:     ctrl_wr_s     = wr_s;
            OFF_LOAD:     load_wr_s     = wr_s;
            OFF_COUNT:    count_wr_s    = wr_s;
            OFF_STATUS:   status_wr_s   = wr_s;
            OFF_PRESCALE: prescale_wr_s = wr_s;
            default:      ctrl_wr_s     = 1'b0;
        endcase
    end

    // Read mux sampling current register values (before this cycle's update)
    always_comb begin
        rd_val_s = 32'd0;
        case (off_s)
            OFF_CTRL:     rd_val_s[2:0]            = {irq_en_r, auto_r, en_r};
            OFF_LOAD:     rd_val_s[CNT_W-1:0]      = load_r;
            OFF_COUNT:    rd_val_s[CNT_W-1:0]      = count_r;
            OFF_STATUS:   rd_val_s[0]              = expired_r;
            OFF_PRESCALE: rd_val_s[PRESCALE_W-1:0] = prescale_r;
            default:      rd_val_s                 = 32'd0;
        endcase
    end

    // Next-state logic: bus writes take priority over counter-driven updates,
    // except that an expire event beats a same-cycle STATUS clear.
    always_comb begin
        if (ctrl_wr_s && bus.data_i[0] && !en_r) begin
            pcnt_nxt_s = {PRESCALE_W{1'b0}};
        end else if (!en_r || tick_s) begin
            pcnt_nxt_s = {PRESCALE_W{1'b0}};
        end else begin
            pcnt_nxt_s = pcnt_r + PRESCALE_W'(1);
        end

        if (count_wr_s) begin
            count_nxt_s = bus.data_i[CNT_W-1:0];
        end else if (tick_s && (count_r != {CNT_W{1'b0}})) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else if (expire_s && auto_r) begin
            count_nxt_s = load_r;
        end else begin
            count_nxt_s = count_r;
        end

        if (ctrl_wr_s) begin
            en_nxt_s     = bus.data_i[0];
            auto_nxt_s   = bus.data_i[1];
            irq_en_nxt_s = bus.data_i[2];
        end else if (expire_s && !auto_r) begin
            en_nxt_s     = 1'b0;
            auto_nxt_s   = auto_r;
            irq_en_nxt_s = irq_en_r;
        end else begin
            en_nxt_s     = en_r;
            auto_nxt_s   = auto_r;
            irq_en_nxt_s = irq_en_r;
        end

        if (load_wr_s) begin
            load_nxt_s = bus.data_i[CNT_W-1:0];
        end else begin
            load_nxt_s = load_r;
        end

        if (prescale_wr_s) begin
            prescale_nxt_s = bus.data_i[PRESCALE_W-1:0];
        end else begin
            prescale_nxt_s = prescale_r;
        end

        if (expire_s) begin
            expired_nxt_s = 1'b1;
        end else if (status_wr_s && bus.data_i[0]) begin
            expired_nxt_s = 1'b0;
        end else begin
            expired_nxt_s = expired_r;
        end

        // Registering the next-state product keeps irq_o flop-driven with no added latency.
        irq_nxt_s = expired_nxt_s & irq_en_nxt_s;
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            en_r       <= 1'b0;
            auto_r     <= 1'b0;
            irq_en_r   <= 1'b0;
            expired_r  <= 1'b0;
            irq_r      <= 1'b0;
            load_r     <= LOAD_RST;
            count_r    <= LOAD_RST;
            prescale_r <= {PRESCALE_W{1'b0}};
            pcnt_r     <= {PRESCALE_W{1'b0}};
            rdata_r    <= 32'd0;
        end else begin
            en_r       <= en_nxt_s;
            auto_r     <= auto_nxt_s;
            irq_en_r   <= irq_en_nxt_s;
            expired_r  <= expired_nxt_s;
            irq_r      <= irq_nxt_s;
            load_r     <= load_nxt_s;
            count_r    <= count_nxt_s;
            prescale_r <= prescale_nxt_s;
            pcnt_r     <= pcnt_nxt_s;
            if (bus.rd_i) begin
                rdata_r <= rd_val_s;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign bus.data_o = rdata_r;
    assign bus.irq_o  = irq_r;

endmodule

// File: tb/tb_bus_timer.sv
// Directed self-checking bench for bus_timer: one task per scenario, each with
// hand-computed expectations checked inline at the falling clock edge.
module tb_bus_timer;

    localparam logic [31:0] A_CTRL     = 32'h00;
    localparam logic [31:0] A_LOAD     = 32'h04;
    localparam logic [31:0] A_COUNT    = 32'h08;
    localparam logic [31:0] A_STATUS   = 32'h0C;
    localparam logic [31:0] A_PRESCALE = 32'h10;
    localparam logic [31:0] A_UNMAPPED = 32'h20;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    bus_timer_if bus_if ();

    bus_timer dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end aligned to a falling edge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus_if.addr_i = addr;
        bus_if.data_i = data;
        bus_if.we_i   = 1'b1;
        @(negedge clk);
        bus_if.we_i   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus_if.addr_i = addr;
        bus_if.rd_i   = 1'b1;
        @(negedge clk);
        bus_if.rd_i   = 1'b0;
        data = bus_if.data_o;
    endtask

    task automatic stop_timer();
        bus_write(A_CTRL, 32'h0);
        bus_write(A_STATUS, 32'h1);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] addrs [6];
        addrs = '{A_CTRL, A_LOAD, A_COUNT, A_STATUS, A_PRESCALE, A_UNMAPPED};
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus_if.irq_o !== 1'b0) begin
            errors++; $display("FAIL reset_irq got=%0b exp=0", bus_if.irq_o);
        end
        checks++;
        if (bus_if.data_o !== 32'h0) begin
            errors++; $display("FAIL reset_data got=%08h exp=00000000", bus_if.data_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            bus_read(addrs[i], rd);
            checks++;
            if (rd !== 32'h0) begin
                errors++; $display("FAIL reset_read addr=%02h got=%08h exp=00000000", addrs[i], rd);
            end
        end
        checks++;
        if (bus_if.irq_o !== 1'b0) begin
            errors++; $display("FAIL reset_irq_after got=%0b exp=0", bus_if.irq_o);
        end
    endtask

    task automatic test_regs();
        logic [31:0] rd;
        bus_write(A_LOAD, 32'hDEADBEEF);
        bus_read(32'h07, rd);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL load_lowbits_ignored got=%08h exp=deadbeef", rd);
        end
        bus_write(A_CTRL, 32'hFFFFFFF8);
        bus_read(A_CTRL, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL ctrl_reserved got=%08h exp=00000000", rd);
        end
        bus_write(A_PRESCALE, 32'hABCD1234);
        bus_read(A_PRESCALE, rd);
        checks++;
        if (rd !== 32'h00001234) begin
            errors++; $display("FAIL prescale_width got=%08h exp=00001234", rd);
        end
        bus_write(A_UNMAPPED, 32'h12345678);
        bus_read(A_UNMAPPED, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL unmapped_read got=%08h exp=00000000", rd);
        end
        bus_write(A_PRESCALE, 32'h0);
    endtask

    task automatic test_auto_reload();
        logic [31:0] exp_cnt [5];
        exp_cnt = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd3};
        stop_timer();
        bus_write(A_PRESCALE, 32'h0);
        bus_write(A_LOAD, 32'h3);
        bus_write(A_COUNT, 32'h3);
        bus_write(A_CTRL, 32'h7);
        repeat (3) @(negedge clk);
        checks++;
        if (bus_if.irq_o !== 1'b0) begin
            errors++; $display("FAIL auto_irq_early got=%0b exp=0", bus_if.irq_o);
        end
        @(negedge clk);
        checks++;
        if (bus_if.irq_o !== 1'b1) begin
            errors++; $display("FAIL auto_irq_rise got=%0b exp=1", bus_if.irq_o);
        end
        bus_if.addr_i = A_COUNT;
        bus_if.rd_i   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus_if.data_o !== exp_cnt[i]) begin
                errors++; $display("FAIL auto_count[%0d] got=%0d exp=%0d", i, bus_if.data_o, exp_cnt[i]);
            end
        end
        bus_if.rd_i = 1'b0;
        bus_write(A_STATUS, 32'h1);
        checks++;
        if (bus_if.irq_o !== 1'b0) begin
            errors++; $display("FAIL auto_w1c got=%0b exp=0", bus_if.irq_o);
        end
        @(negedge clk);
        checks++;
        if (bus_if.irq_o !== 1'b0) begin
            errors++; $display("FAIL auto_period_early got=%0b exp=0", bus_if.irq_o);
        end
        @(negedge clk);
        checks++;
        if (bus_if.irq_o !== 1'b1) begin
            errors++; $display("FAIL auto_period_rise got=%0b exp=1", bus_if.irq_o);
        end
    endtask

    task automatic test_one_shot();
        logic [31:0] rd;
        stop_timer();
        bus_write(A_PRESCALE, 32'd9);
        bus_write(A_COUNT, 32'd2);
        bus_write(A_CTRL, 32'h5);
        repeat (29) @(negedge clk);
        checks++;
        if (bus_if.irq_o !== 1'b0) begin
            errors++; $display("FAIL oneshot_early got=%0b exp=0", bus_if.irq_o);
        end
        @(negedge clk);
        checks++;
        if (bus_if.irq_o !== 1'b1) begin
            errors++; $display("FAIL oneshot_expire got=%0b exp=1", bus_if.irq_o);
        end
        bus_read(A_CTRL, rd);
        checks++;
        if (rd !== 32'h4) begin
            errors++; $display("FAIL oneshot_ctrl got=%08h exp=00000004", rd);
        end
        repeat (25) @(negedge clk);
        bus_read(A_COUNT, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL oneshot_count got=%08h exp=00000000", rd);
        end
    endtask

    task automatic test_w1c_collision();
        stop_timer();
        bus_write(A_PRESCALE, 32'h0);
        bus_write(A_LOAD, 32'h3);
        bus_write(A_COUNT, 32'h3);
        bus_write(A_CTRL, 32'h7);
        repeat (3) @(negedge clk);
        bus_write(A_STATUS, 32'h1);
        checks++;
        if (bus_if.irq_o !== 1'b1) begin
            errors++; $display("FAIL w1c_collision got=%0b exp=1", bus_if.irq_o);
        end
        bus_write(A_STATUS, 32'h1);
        checks++;
        if (bus_if.irq_o !== 1'b0) begin
            errors++; $display("FAIL w1c_later got=%0b exp=0", bus_if.irq_o);
        end
    endtask

    task automatic test_bus_priority();
        logic [31:0] rd;
        stop_timer();
        bus_write(A_COUNT, 32'h20);
        bus_if.addr_i = A_COUNT;
        bus_if.data_i = 32'h55;
        bus_if.rd_i   = 1'b1;
        bus_if.we_i   = 1'b1;
        @(negedge clk);
        bus_if.rd_i   = 1'b0;
        bus_if.we_i   = 1'b0;
        checks++;
        if (bus_if.data_o !== 32'h20) begin
            errors++; $display("FAIL rdwr_old_value got=%08h exp=00000020", bus_if.data_o);
        end
        bus_read(A_COUNT, rd);
        checks++;
        if (rd !== 32'h20) begin
            errors++; $display("FAIL rdwr_no_write got=%08h exp=00000020", rd);
        end
        bus_write(A_LOAD, 32'h100);
        bus_write(A_COUNT, 32'h30);
        bus_write(A_CTRL, 32'h1);
        bus_write(A_COUNT, 32'h10);
        bus_read(A_COUNT, rd);
        checks++;
        if (rd !== 32'h10) begin
            errors++; $display("FAIL count_write_on_tick got=%08h exp=00000010", rd);
        end
    endtask

    task automatic test_reset_mid_count();
        logic [31:0] rd;
        logic [31:0] addrs [5];
        int          waited;
        addrs = '{A_CTRL, A_LOAD, A_COUNT, A_STATUS, A_PRESCALE};
        stop_timer();
        bus_write(A_PRESCALE, 32'h1);
        bus_write(A_LOAD, 32'h2);
        bus_write(A_COUNT, 32'h2);
        bus_write(A_CTRL, 32'h7);
        waited = 0;
        while (bus_if.irq_o !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (bus_if.irq_o !== 1'b1) begin
            errors++; $display("FAIL midrst_irq_timeout got=%0b exp=1", bus_if.irq_o);
        end
        bus_read(A_LOAD, rd);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus_if.irq_o !== 1'b0) begin
            errors++; $display("FAIL midrst_irq got=%0b exp=0", bus_if.irq_o);
        end
        checks++;
        if (bus_if.data_o !== 32'h0) begin
            errors++; $display("FAIL midrst_data got=%08h exp=00000000", bus_if.data_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus_read(addrs[i], rd);
            checks++;
            if (rd !== 32'h0) begin
                errors++; $display("FAIL midrst_read addr=%02h got=%08h exp=00000000", addrs[i], rd);
            end
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        bus_if.addr_i = 32'h0;
        bus_if.data_i = 32'h0;
        bus_if.rd_i   = 1'b0;
        bus_if.we_i   = 1'b0;
        test_reset();
        test_regs();
        test_auto_reload();
        test_one_shot();
        test_w1c_collision();
        test_bus_priority();
        test_reset_mid_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
